rob_ctrl: RTL

//  Reorder-buffer controller that drives the dual-port ROB storage RAM (2 write, 2 registered read ports).

---
 rtl/rob_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: in-order dual allocation, out-of-order completion tracking,
// dual in-order retirement aligned with the ROB RAM's registered read port.
module rob_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ADDR  = 4,
    parameter int unsigned DEPTH = 1 << ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_req_0,
    input  logic              alloc_req_1,
    input  logic [WIDTH-1:0]  alloc_data_0,
    input  logic [WIDTH-1:0]  alloc_data_1,
    output logic              alloc_gnt_0,
    output logic              alloc_gnt_1,
    output logic [ADDR-1:0]   alloc_tag_0,
    output logic [ADDR-1:0]   alloc_tag_1,
    input  logic              cmpl_vld,
    input  logic [ADDR-1:0]   cmpl_tag,
    input  logic              retire_rdy,
    output logic              retire_vld_0,
    output logic              retire_vld_1,
    output logic [ADDR-1:0]   retire_tag_0,
    output logic [ADDR-1:0]   retire_tag_1,
    input  logic              flush,
    output logic [ADDR:0]     count,
    output logic              full,
    output logic              empty,
    output logic              ram_wr_en_0,
    output logic              ram_wr_en_1,
    output logic [ADDR-1:0]   ram_addr_in_0,
    output logic [ADDR-1:0]   ram_addr_in_1,
    output logic [WIDTH-1:0]  ram_data_in_0,
    output logic [WIDTH-1:0]  ram_data_in_1,
    output logic              ram_o_en_0,
    output logic              ram_o_en_1,
    output logic [ADDR-1:0]   ram_addr_out_0,
    output logic [ADDR-1:0]   ram_addr_out_1
);

    localparam int unsigned CW = ADDR + 1;

    logic [ADDR-1:0]  head, tail;
    logic [DEPTH-1:0] done;

    logic [ADDR-1:0]  head_p1, tail_p1, cmpl_ofs;
    logic [ADDR-1:0]  head_nxt, tail_nxt;
    logic [CW-1:0]    count_nxt;
    logic [DEPTH-1:0] done_nxt;
    logic             gnt0, gnt1, r0, r1, cmpl_hit;

    // Grants use the pre-retire count; flush suppresses everything in its cycle.
    always_comb begin
        head_p1   = head + ADDR'(1);
        tail_p1   = tail + ADDR'(1);
        gnt0      = alloc_req_0 & (count <= CW'(DEPTH - 1)) & ~flush;
        gnt1      = alloc_req_0 & alloc_req_1 & (count <= CW'(DEPTH - 2)) & ~flush;
        cmpl_ofs  = cmpl_tag - head;
        cmpl_hit  = cmpl_vld & ~flush & (CW'(cmpl_ofs) < count);
        r0        = retire_rdy & ~flush & (count != CW'(0)) & done[head];
        r1        = r0 & (count >= CW'(2)) & done[head_p1];

        done_nxt  = done;
        if (cmpl_hit) done_nxt[cmpl_tag] = 1'b1;
        if (gnt0)     done_nxt[tail]     = 1'b0;
        if (gnt1)     done_nxt[tail_p1]  = 1'b0;

        count_nxt = count + CW'(gnt0) + CW'(gnt1) - CW'(r0) - CW'(r1);
        tail_nxt  = tail + ADDR'(gnt0) + ADDR'(gnt1);
        head_nxt  = head + ADDR'(r0) + ADDR'(r1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            done         <= '0;
            retire_vld_0 <= 1'b0;
            retire_vld_1 <= 1'b0;
            retire_tag_0 <= '0;
            retire_tag_1 <= '0;
        end else if (flush) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            done         <= '0;
            retire_vld_0 <= 1'b0;
            retire_vld_1 <= 1'b0;
        end else begin
            head         <= head_nxt;
            tail         <= tail_nxt;
            count        <= count_nxt;
            done         <= done_nxt;
            retire_vld_0 <= r0;
            retire_vld_1 <= r1;
            // Tags hold their last retired value while nothing retires.
            if (r0) begin
                retire_tag_0 <= head;
                retire_tag_1 <= head_p1;
            end
        end
    end

    assign alloc_gnt_0    = gnt0;
    assign alloc_gnt_1    = gnt1;
    assign alloc_tag_0    = tail;
    assign alloc_tag_1    = tail_p1;
    assign full           = (count == CW'(DEPTH));
    assign empty          = (count == CW'(0));
    assign ram_wr_en_0    = gnt0;
    assign ram_wr_en_1    = gnt1;
    assign ram_addr_in_0  = tail;
    assign ram_addr_in_1  = tail_p1;
    assign ram_data_in_0  = alloc_data_0;
    assign ram_data_in_1  = alloc_data_1;
    assign ram_o_en_0     = r0;
    assign ram_o_en_1     = r1;
    assign ram_addr_out_0 = head;
    assign ram_addr_out_1 = head_p1;

endmodule
